tail_light_ctrl: RTL and testbench
==================================

# tail_light_ctrl

Sequencing controller for the six-lamp tail-light datapath (three left lamps, three right lamps). It arbitrates the driver's left, right, hazard and brake controls and paces the turn animation with an internal step prescaler. It drives the registered 6-bit lamp vector `y` directly. It sits between the debounced switch inputs and the lamp outputs and replaces free-running per-clock stepping with a paced, prioritised sequence.

## Interface
- `TICK_DIV`, default 4: clock cycles per animation step; legal range ≥ 2. The prescaler counter width is $clog2(TICK_DIV).
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `left`  in  1  left turn request, level-sensitive.
- `right`  in  1  right turn request, level-sensitive.
- `hazard`  in  1  hazard request, level-sensitive.
- `brake`  in  1  brake request, level-sensitive.
- `y`  out  6  lamp vector, registered.
  - `y[5]`=LC, `y[4]`=LB, `y[3]`=LA (outer to inner on the left side).
  - `y[2]`=RA, `y[1]`=RB, `y[0]`=RC (inner to outer on the right side).
- `active`  out  1  registered; high whenever the state is not IDLE.

## Operation
- States: IDLE, L1, L2, L3, R1, R2, R3, HON, HOFF.
- Request decode, evaluated at every decision point:
  - HAZ = `hazard` | (`left` & `right`).
  - LREQ = `left` & ~`right` & ~`hazard`.
  - RREQ = `right` & ~`left` & ~`hazard`.
  - Priority: HAZ > LREQ/RREQ (these two are mutually exclusive by construction).
- Prescaler `cnt`:
  - Held at 0 in IDLE and on every state entry.
  - Otherwise increments each cycle.
  - `tick` = (`cnt` == TICK_DIV-1).
- Transitions:
  - IDLE: HAZ→HON, LREQ→L1, RREQ→R1, else stay. Taken on the same edge the request is sampled; no tick wait.
  - L1→L2 and L2→L3 on tick.
  - L3 on tick: HAZ→HON, LREQ→L1, RREQ→R1, else IDLE.
  - R1, R2, R3: mirror of L1, L2, L3.
  - Hazard pre-emption: in any L or R state, HAZ forces →HON on the next edge regardless of tick.
  - A direction change mid-sequence (e.g. `right` while in L2) is ignored until the decision at L3/R3.
  - Releasing the turn switch mid-sequence does not abort; the sequence completes to L3/R3.
  - HON on tick→HOFF, even if HAZ has dropped.
  - HOFF on tick: HAZ→HON, LREQ→L1, RREQ→R1, else IDLE.
- Lamp pattern by next state:
  - IDLE: 000000.
  - L1: 001000. L2: 011000. L3: 111000.
  - R1: 000100. R2: 000110. R3: 000111.
  - HON: 111111. HOFF: 000000.
- Brake overlay, applied when `brake`=1:
  - IDLE: all six lamps on (111111).
  - L states: right half forced to 111.
  - R states: left half forced to 111.
  - HON/HOFF: no effect; the hazard pattern wins.
- `y` and `active` are registered from next state and the current `brake`.

## Timing
- Reset (sync): state=IDLE, `cnt`=0, `y`=000000, `active`=0.
  - Reset overrides all requests.
  - Reset asserted mid-sequence returns to IDLE with dark lamps on the next edge.
- Request latency: a request sampled at edge n in IDLE is visible on `y` after edge n (one registered stage).
- Each L, R, HON and HOFF state lasts exactly TICK_DIV cycles unless pre-empted.
- Full left cycle = 3·TICK_DIV cycles. Full hazard period = 2·TICK_DIV cycles.
- Brake latency: 1 cycle (register), independent of tick.
- Simultaneous events:
  - `left`&`right` is treated as hazard.
  - `hazard` together with any other request is treated as hazard.
  - Brake together with a turn produces the overlay described in Operation.

## Test plan
All cases use TICK_DIV=4.
- Reset for 2 cycles with `right`=1 held: `y`=000000 and `active`=0 during reset. Then `y` shows 000100 for 4 cycles, 000110 for 4, 000111 for 4, and repeats while `right` stays high.
- Left pulse: `left`=1 for a single cycle in IDLE → 001000, 011000, 111000 (4 cycles each), then IDLE with 000000. Total 12 active cycles.
- `hazard` asserted while in L2 → next edge `y`=111111 for 4 cycles, then 000000 for 4 cycles. When `hazard` is released during HON, the controller completes HOFF and then goes to IDLE.
- `left`=`right`=1 from IDLE → alternating 111111 and 000000, 4 cycles each. `active`=1 throughout.
- `brake`=1 alone gives 111111 one cycle after assertion. `brake`=1 with `left`=1 gives 001111, 011111, 111111 for the three left steps.
- `right` asserted while in L1 → the left sequence completes through L3 unchanged. Then, if only `right` is high at the L3 tick, the next state is R1 (000100).

Source files
------------

// File: rtl/tail_light_ctrl.sv
// tail_light_ctrl: paced, prioritised six-lamp tail-light sequencer with brake overlay
module tail_light_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic [5:0] y,
    output logic       active
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [3:0] {IDLE, L1, L2, L3, R1, R2, R3, HON, HOFF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    y_q, y_d;
    logic          active_q, active_d;
    logic          haz, lreq, rreq, tick;
    state_t        pick;

    // next state, step prescaler and lamp pattern from the next state plus brake
    always_comb begin
        haz      = hazard | (left & right);
        lreq     = left & ~right & ~hazard;
        rreq     = right & ~left & ~hazard;
        tick     = cnt_q == CW'(TICK_DIV - 1);
        pick     = haz ? HON : lreq ? L1 : rreq ? R1 : IDLE;
        state_d  = state_q;
        unique case (state_q)
            IDLE:    state_d = pick;
            L1:      state_d = haz ? HON : tick ? L2 : L1;
            L2:      state_d = haz ? HON : tick ? L3 : L2;
            L3:      state_d = haz ? HON : tick ? pick : L3;
            R1:      state_d = haz ? HON : tick ? R2 : R1;
            R2:      state_d = haz ? HON : tick ? R3 : R2;
            R3:      state_d = haz ? HON : tick ? pick : R3;
            HON:     state_d = tick ? HOFF : HON;
            HOFF:    state_d = tick ? pick : HOFF;
            default: state_d = IDLE;
        endcase
        cnt_d    = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
        y_d      = 6'b000000;
        unique case (state_d)
            L1:      y_d = 6'b001000;
            L2:      y_d = 6'b011000;
            L3:      y_d = 6'b111000;
            R1:      y_d = 6'b000100;
            R2:      y_d = 6'b000110;
            R3:      y_d = 6'b000111;
            HON:     y_d = 6'b111111;
            default: y_d = 6'b000000;
        endcase
        if (brake) begin
            if (state_d == IDLE) y_d = 6'b111111;
            else if (state_d inside {L1, L2, L3}) y_d[2:0] = 3'b111;
            else if (state_d inside {R1, R2, R3}) y_d[5:3] = 3'b111;
        end
        active_d = state_d != IDLE;
    end

    // state, prescaler and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            active_q <= active_d;
        end
    end

    assign y      = y_q;
    assign active = active_q;
endmodule

// File: tb/tb_tail_light_ctrl.sv
// tb_tail_light_ctrl: directed checks of the tail-light sequencer at TICK_DIV=4
module tb_tail_light_ctrl;
    logic       clk = 1'b0;
    logic       reset, left, right, hazard, brake;
    logic [5:0] y;
    logic       active;
    int         total = 0;
    int         bad = 0;

    tail_light_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard), .brake(brake), .y(y), .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; left = 0; right = 1; hazard = 0; brake = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_y", {2'b0, y}, 8'h00);
            chk("rst_act", {7'b0, active}, 8'h01 & 8'h00);
        end
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("right_seq", {2'b0, y}, i < 4 ? 8'b000100 : i < 8 ? 8'b000110 : 8'b000111);
            chk("right_act", {7'b0, active}, 8'h01);
        end
        step();
        chk("right_repeat", {2'b0, y}, 8'b000100);
        right = 0; reset = 1;
        step();
        chk("mid_rst_y", {2'b0, y}, 8'h00);
        chk("mid_rst_act", {7'b0, active}, 8'h00);
        reset = 0;
        step();
        chk("idle_y", {2'b0, y}, 8'h00);

        left = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            left = 0;
            chk("left_pulse", {2'b0, y}, i < 4 ? 8'b001000 : i < 8 ? 8'b011000 : 8'b111000);
        end
        step();
        chk("left_end_y", {2'b0, y}, 8'h00);
        chk("left_end_act", {7'b0, active}, 8'h00);

        left = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            left = 0;
        end
        chk("in_l2", {2'b0, y}, 8'b011000);
        hazard = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) hazard = 0;
            chk("haz_on", {2'b0, y}, 8'b111111);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("haz_off_y", {2'b0, y}, 8'h00);
            chk("haz_off_act", {7'b0, active}, 8'h01);
        end
        step();
        chk("haz_idle_act", {7'b0, active}, 8'h00);

        left = 1; right = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("lr_haz_y", {2'b0, y}, ((i / 4) % 2 == 0) ? 8'b111111 : 8'h00);
            chk("lr_haz_act", {7'b0, active}, 8'h01);
        end
        left = 0; right = 0;
        step();
        chk("lr_idle_act", {7'b0, active}, 8'h00);

        brake = 1;
        step();
        chk("brake_idle", {2'b0, y}, 8'b111111);
        chk("brake_idle_act", {7'b0, active}, 8'h00);
        brake = 0;
        step();
        chk("brake_rel", {2'b0, y}, 8'h00);

        brake = 1; left = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            left = 0;
            chk("brake_left", {2'b0, y}, i < 4 ? 8'b001111 : i < 8 ? 8'b011111 : 8'b111111);
        end
        brake = 0;
        step();
        chk("brake_left_end", {2'b0, y}, 8'h00);

        left = 1;
        step();
        left = 0; right = 1;
        chk("dir_l1", {2'b0, y}, 8'b001000);
        for (int i = 1; i < 12; i++) begin
            step();
            chk("dir_ignore", {2'b0, y}, i < 4 ? 8'b001000 : i < 8 ? 8'b011000 : 8'b111000);
        end
        step();
        chk("dir_to_r1", {2'b0, y}, 8'b000100);
        right = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
